// File: rtl/parking_occupancy_ctrl.sv
// Parking front end: turns entry/exit request edges into a registered occupancy
// vector, allocates the lowest free spot per entry and times the barrier gate.
module parking_occupancy_ctrl #(
    parameter int GATE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enter_req,
    input  logic       exit_req,
    input  logic [1:0] exit_spot,
    output logic [3:0] occ,
    output logic       enter_grant,
    output logic [1:0] enter_spot,
    output logic       enter_deny,
    output logic       exit_ack,
    output logic       exit_err,
    output logic       gate_open,
    output logic       busy
);

    typedef enum logic {IDLE, GATE} state_t;

    state_t     state;
    logic       enter_q, exit_q;
    logic       enter_pend, exit_pend;
    logic [1:0] exit_spot_q;
    logic [7:0] gate_cnt;

    logic enter_edge, exit_edge;
    logic serve_exit, serve_enter;

    function automatic logic [1:0] lowest_free(input logic [3:0] v);
        if (!v[0])      return 2'd0;
        else if (!v[1]) return 2'd1;
        else if (!v[2]) return 2'd2;
        else            return 2'd3;
    endfunction

    always_comb begin
        enter_edge  = enter_req & ~enter_q;
        exit_edge   = exit_req & ~exit_q;
        serve_exit  = (state == IDLE) && exit_pend;
        serve_enter = (state == IDLE) && !exit_pend && enter_pend;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            enter_q     <= 1'b0;
            exit_q      <= 1'b0;
            enter_pend  <= 1'b0;
            exit_pend   <= 1'b0;
            exit_spot_q <= 2'd0;
            gate_cnt    <= 8'd0;
            occ         <= 4'b0000;
            enter_spot  <= 2'd0;
            enter_grant <= 1'b0;
            enter_deny  <= 1'b0;
            exit_ack    <= 1'b0;
            exit_err    <= 1'b0;
            gate_open   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            enter_q     <= enter_req;
            exit_q      <= exit_req;
            enter_grant <= 1'b0;
            enter_deny  <= 1'b0;
            exit_ack    <= 1'b0;
            exit_err    <= 1'b0;

            // A new edge landing on the cycle its latch is served is kept, not lost.
            enter_pend <= enter_edge | (enter_pend & ~serve_enter);
            exit_pend  <= exit_edge | (exit_pend & ~serve_exit);
            if (exit_edge && (!exit_pend || serve_exit))
                exit_spot_q <= exit_spot;

            case (state)
                IDLE: begin
                    if (serve_exit) begin
                        if (occ[exit_spot_q]) begin
                            occ       <= occ & ~(4'b0001 << exit_spot_q);
                            exit_ack  <= 1'b1;
                            gate_cnt  <= 8'(GATE_CYCLES);
                            gate_open <= 1'b1;
                            busy      <= 1'b1;
                            state     <= GATE;
                        end else begin
                            exit_err <= 1'b1;
                        end
                    end else if (serve_enter) begin
                        if (occ != 4'b1111) begin
                            occ         <= occ | (4'b0001 << lowest_free(occ));
                            enter_spot  <= lowest_free(occ);
                            enter_grant <= 1'b1;
                            gate_cnt    <= 8'(GATE_CYCLES);
                            gate_open   <= 1'b1;
                            busy        <= 1'b1;
                            state       <= GATE;
                        end else begin
                            enter_deny <= 1'b1;
                        end
                    end
                end
                GATE: begin
                    if (gate_cnt == 8'd1) begin
                        gate_open <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        gate_cnt <= gate_cnt - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_parking_occupancy_ctrl.sv
// Directed bench for parking_occupancy_ctrl: a GATE_CYCLES=8 instance for the
// main scenarios and a GATE_CYCLES=1 instance for the minimum gate length.
module tb_parking_occupancy_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       enter_req, exit_req;
    logic [1:0] exit_spot;
    logic [3:0] occ;
    logic       enter_grant, enter_deny, exit_ack, exit_err, gate_open, busy;
    logic [1:0] enter_spot;

    logic       enter_req1, exit_req1;
    logic [1:0] exit_spot1;
    logic [3:0] occ1;
    logic       enter_grant1, enter_deny1, exit_ack1, exit_err1, gate_open1, busy1;
    logic [1:0] enter_spot1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    parking_occupancy_ctrl #(.GATE_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .enter_req(enter_req), .exit_req(exit_req),
        .exit_spot(exit_spot), .occ(occ), .enter_grant(enter_grant),
        .enter_spot(enter_spot), .enter_deny(enter_deny), .exit_ack(exit_ack),
        .exit_err(exit_err), .gate_open(gate_open), .busy(busy)
    );

    parking_occupancy_ctrl #(.GATE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .enter_req(enter_req1), .exit_req(exit_req1),
        .exit_spot(exit_spot1), .occ(occ1), .enter_grant(enter_grant1),
        .enter_spot(enter_spot1), .enter_deny(enter_deny1), .exit_ack(exit_ack1),
        .exit_err(exit_err1), .gate_open(gate_open1), .busy(busy1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse enter_req for one cycle; returns just after the serving edge.
    task automatic do_enter();
        enter_req = 1'b1;
        tick();
        enter_req = 1'b0;
        tick();
    endtask

    task automatic do_exit(input logic [1:0] spot);
        exit_spot = spot;
        exit_req  = 1'b1;
        tick();
        exit_req  = 1'b0;
        tick();
    endtask

    // Counts cycles gate_open stays high from now; bounded.
    task automatic gate_len(input string tag, input int exp);
        int n = 0;
        while (gate_open && n < 300) begin
            n++;
            tick();
        end
        chk(tag, n, exp);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic saw_grant;
        rst = 1'b1; enter_req = 1'b0; exit_req = 1'b0; exit_spot = 2'd0;
        enter_req1 = 1'b0; exit_req1 = 1'b0; exit_spot1 = 2'd0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_occ", occ, 4'b0000);
        chk("rst_gate", gate_open, 0);
        chk("rst_busy", busy, 0);
        chk("rst_spot", enter_spot, 0);
        chk("rst_pulses", {enter_grant, enter_deny, exit_ack, exit_err}, 0);

        do_enter();
        chk("e1_occ", occ, 4'b0001);
        chk("e1_grant", enter_grant, 1);
        chk("e1_spot", enter_spot, 0);
        chk("e1_gate", gate_open, 1);
        chk("e1_busy", busy, 1);
        gate_len("e1_gatelen", 8);
        chk("e1_grant_drop", enter_grant, 0);

        do_enter();
        chk("e2_occ", occ, 4'b0011);
        chk("e2_spot", enter_spot, 1);
        gate_len("e2_gatelen", 8);
        do_enter();
        chk("e3_occ", occ, 4'b0111);
        chk("e3_spot", enter_spot, 2);
        gate_len("e3_gatelen", 8);
        do_enter();
        chk("e4_occ", occ, 4'b1111);
        chk("e4_spot", enter_spot, 3);
        gate_len("e4_gatelen", 8);

        do_enter();
        chk("full_deny", enter_deny, 1);
        chk("full_grant", enter_grant, 0);
        chk("full_occ", occ, 4'b1111);
        chk("full_gate", gate_open, 0);
        chk("full_busy", busy, 0);
        tick();
        chk("full_deny_drop", enter_deny, 0);

        do_exit(2'd2);
        chk("x2_ack", exit_ack, 1);
        chk("x2_occ", occ, 4'b1011);
        chk("x2_gate", gate_open, 1);
        gate_len("x2_gatelen", 8);
        do_enter();
        chk("re_spot", enter_spot, 2);
        chk("re_occ", occ, 4'b1111);
        gate_len("re_gatelen", 8);

        // Exit and entry rise together on a full lot.
        enter_req = 1'b1; exit_req = 1'b1; exit_spot = 2'd1;
        tick();
        enter_req = 1'b0; exit_req = 1'b0;
        tick();
        chk("sim_ack", exit_ack, 1);
        chk("sim_nogrant", enter_grant, 0);
        chk("sim_occ", occ, 4'b1101);
        for (int i = 0; i < 8; i++) tick();
        chk("sim_wait_grant", enter_grant, 0);
        chk("sim_wait_gate", gate_open, 0);
        tick();
        chk("sim_grant", enter_grant, 1);
        chk("sim_spot", enter_spot, 1);
        chk("sim_occ2", occ, 4'b1111);
        gate_len("sim_gatelen", 8);

        // Exit naming a free spot.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        do_enter();
        gate_len("pre_err_gatelen", 8);
        chk("pre_err_occ", occ, 4'b0001);
        do_exit(2'd3);
        chk("err_pulse", exit_err, 1);
        chk("err_ack", exit_ack, 0);
        chk("err_occ", occ, 4'b0001);
        chk("err_gate", gate_open, 0);
        chk("err_busy", busy, 0);
        tick();
        chk("err_drop", exit_err, 0);

        // Reset mid-gate with an entry pending.
        do_enter();
        chk("mid_occ", occ, 4'b0011);
        tick();
        enter_req = 1'b1;
        tick();
        enter_req = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_occ", occ, 4'b0000);
        chk("mid_rst_gate", gate_open, 0);
        chk("mid_rst_busy", busy, 0);
        saw_grant = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (enter_grant) saw_grant = 1'b1;
        end
        chk("mid_rst_nograant", saw_grant, 0);
        chk("mid_rst_occ2", occ, 4'b0000);

        // Minimum gate length on the GATE_CYCLES=1 instance.
        enter_req1 = 1'b1;
        tick();
        enter_req1 = 1'b0;
        tick();
        chk("g1_grant", enter_grant1, 1);
        chk("g1_gate", gate_open1, 1);
        chk("g1_occ", occ1, 4'b0001);
        tick();
        chk("g1_gate_off", gate_open1, 0);
        chk("g1_busy_off", busy1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
